cpu_run_ctrl: RTL and testbench

- Run-control stage directly upstream of the pipelined processor.
- Replaces the combinational clock gating of the divided clock by init with a glitch-free, registered clock enable (cpu_en) in the clk_50Mhz domain.
- Synchronizes and debounces the board init switch and step button, and supports free-run, single-step and halt-on-request.
- Maintains an executed-cycle counter for debug display.

---
 rtl/cpu_run_ctrl_pkg.sv | 25 ++
 rtl/cpu_run_ctrl_debouncer.sv | 52 +++++
 rtl/cpu_run_ctrl.sv | 137 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the processor run-control stage.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALT      = 2'd3
  } run_state_t;

  localparam int DEFAULT_DIV      = 2;
  localparam int DEFAULT_DEBOUNCE = 500000;

  // States in which a prescaler tick is turned into a processor clock enable.
  function automatic logic is_issuing(input run_state_t st);
    logic act;
    case (st)
      RUN:       act = 1'b1;
      STEP_WAIT: act = 1'b1;
      default:   act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_debouncer.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge pulse
// for one raw board input.
module input_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic [CW-1:0] cnt_r;

  // Sync the raw level, then accept it only after it differs long enough.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= CNT_ZERO;
    end else begin
      sync1_r   <= raw;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level = level_r;
  assign rise  = level_r & ~level_d_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the pipelined processor: debounced run/step inputs,
// prescaled registered clock enable, halt handling and an executed-cycle counter.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV             = DEFAULT_DIV,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W           = 32
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [7:0]       PCNT_LAST = 8'(DIV - 1);
  localparam logic [7:0]       PCNT_ONE  = 8'd1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic             init_db_s;
  logic             init_rise_s;
  logic             step_level_unused_s;
  logic             step_rise_s;
  logic             tick_s;
  logic [7:0]       pcnt_r;
  run_state_t       state_r;
  run_state_t       state_nxt_s;
  logic             cpu_en_r;
  logic             running_r;
  logic             halted_r;
  logic [CNT_W-1:0] count_r;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_init_db (
    .clk   (clk_50Mhz),
    .rst   (rst),
    .raw   (init),
    .level (init_db_s),
    .rise  (init_rise_s)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk   (clk_50Mhz),
    .rst   (rst),
    .raw   (step),
    .level (step_level_unused_s),
    .rise  (step_rise_s)
  );

  assign tick_s = (pcnt_r == PCNT_LAST);

  // Free-running prescaler, independent of the run state.
  always_ff @(posedge clk_50Mhz) begin
    if (!rst) begin
      pcnt_r <= 8'd0;
    end else if (tick_s) begin
      pcnt_r <= 8'd0;
    end else begin
      pcnt_r <= pcnt_r + PCNT_ONE;
    end
  end

  // Next-state selection; earlier conditions win.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (init_db_s) begin
          state_nxt_s = RUN;
        end else if (step_rise_s) begin
          state_nxt_s = STEP_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (halt_req && cpu_en_r) begin
          state_nxt_s = HALT;
        end else if (!init_db_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STEP_WAIT: begin
        if (tick_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STEP_WAIT;
        end
      end
      HALT: begin
        if (init_rise_s) begin
          state_nxt_s = RUN;
        end else if (step_rise_s && !init_db_s) begin
          state_nxt_s = STEP_WAIT;
        end else begin
          state_nxt_s = HALT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with status flags, clock enable and saturating counter.
  always_ff @(posedge clk_50Mhz) begin
    if (!rst) begin
      state_r   <= IDLE;
      running_r <= 1'b0;
      halted_r  <= 1'b0;
      cpu_en_r  <= 1'b0;
      count_r   <= CNT_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == RUN);
      halted_r  <= (state_nxt_s == HALT);
      cpu_en_r  <= tick_s & is_issuing(state_r);
      if (cpu_en_r && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign cpu_en      = cpu_en_r;
  assign running     = running_r;
  assign halted      = halted_r;
  assign cycle_count = count_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized
// stimulus, every cycle compared against a behavioural model.
module tb_cpu_run_ctrl;

  localparam int DIV = 2;
  localparam int DEB = 4;
  localparam int W   = 8;
  localparam int CMAX = 255;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic         clk_50Mhz = 1'b0;
  logic         rst       = 1'b0;
  logic         init      = 1'b0;
  logic         step      = 1'b0;
  logic         halt_req  = 1'b0;
  logic         cpu_en;
  logic         running;
  logic         halted;
  logic [W-1:0] cycle_count;

  int checks = 0;
  int errors = 0;

  // model state
  int     m_st   = M_IDLE;
  bit     m_en   = 1'b0;
  int     m_cnt  = 0;
  int     m_cyc  = 0;
  bit [1:0] i_pipe = 2'b00;
  bit [1:0] s_pipe = 2'b00;
  bit     m_idb = 1'b0, m_sdb = 1'b0;
  int     m_irun = 0, m_srun = 0;
  bit     m_irise = 1'b0, m_srise = 1'b0;

  cpu_run_ctrl #(.DIV(DIV), .DEBOUNCE_CYCLES(DEB), .CNT_W(W)) dut (
    .clk_50Mhz   (clk_50Mhz),
    .rst         (rst),
    .init        (init),
    .step        (step),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .running     (running),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // A level is accepted once DEB consecutive synced samples disagree with it.
  function automatic void deb_step(input bit synced, input bit db_in, input int run_in,
                                   output bit db_out, output int run_out, output bit rise);
    db_out = db_in; run_out = run_in; rise = 1'b0;
    if (synced == db_in) run_out = 0;
    else begin
      run_out = run_in + 1;
      if (run_out == DEB) begin
        db_out = synced; run_out = 0; rise = synced;
      end
    end
  endfunction

  task automatic model_step();
    bit tick;
    int nst;
    bit ndb, nr;
    int nrun;
    if (!rst) begin
      m_st = M_IDLE; m_en = 0; m_cnt = 0; m_cyc = 0;
      i_pipe = 0; s_pipe = 0; m_idb = 0; m_sdb = 0;
      m_irun = 0; m_srun = 0; m_irise = 0; m_srise = 0;
      return;
    end
    tick = ((m_cyc % DIV) == DIV - 1);
    nst = m_st;
    if (m_st == M_IDLE) begin
      if (m_idb) nst = M_RUN; else if (m_srise) nst = M_STEP;
    end else if (m_st == M_RUN) begin
      if (halt_req && m_en) nst = M_HALT; else if (!m_idb) nst = M_IDLE;
    end else if (m_st == M_STEP) begin
      if (tick) nst = M_IDLE;
    end else begin
      if (m_irise) nst = M_RUN; else if (m_srise && !m_idb) nst = M_STEP;
    end
    if (m_en && m_cnt < CMAX) m_cnt++;
    m_en = tick && (m_st == M_RUN || m_st == M_STEP);
    m_st = nst;
    deb_step(i_pipe[1], m_idb, m_irun, ndb, nrun, nr);
    m_idb = ndb; m_irun = nrun; m_irise = nr;
    deb_step(s_pipe[1], m_sdb, m_srun, ndb, nrun, nr);
    m_sdb = ndb; m_srun = nrun; m_srise = nr;
    i_pipe = {i_pipe[0], init};
    s_pipe = {s_pipe[0], step};
    m_cyc++;
  endtask

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic cyc();
    @(posedge clk_50Mhz);
    model_step();
    @(negedge clk_50Mhz);
    chk("cpu_en", cpu_en, m_en);
    chk("running", running, (m_st == M_RUN));
    chk("halted", halted, (m_st == M_HALT));
    chk("cycle_count", cycle_count, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
  endtask

  task automatic wait_running(input string name, input int bound);
    int g = 0;
    while (running !== 1'b1 && g < bound) begin cyc(); g++; end
    chk(name, running, 1);
  endtask

  initial begin
    int n, g, seen;
    @(negedge clk_50Mhz);

    // 1. reset then idle
    do_reset();
    chk("rst_en", cpu_en, 0);
    chk("rst_run", running, 0);
    chk("rst_halt", halted, 0);
    chk("rst_cnt", cycle_count, 0);
    seen = 0;
    repeat (50) begin
      cyc();
      seen = seen | int'(cpu_en) | int'(running) | int'(halted) | int'(cycle_count);
    end
    chk("idle_quiet", seen, 0);

    // 2. free run
    init = 1'b1;
    repeat (6) cyc();
    chk("run_lat6", running, 0);
    cyc();
    chk("run_lat7", running, 1);
    n = 0; g = 0;
    while (n < 20 && g < 200) begin cyc(); if (cpu_en) n++; g++; end
    chk("pulses20", n, 20);
    cyc();
    chk("count20", cycle_count, 20);
    init = 1'b0;
    repeat (6) cyc();
    chk("stop_lat6", running, 1);
    cyc();
    chk("stop_lat7", running, 0);
    cyc();
    seen = 0;
    repeat (10) begin seen = seen | int'(cpu_en); cyc(); end
    chk("en_off", seen, 0);

    // 3. bounce rejection
    do_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      init = (((i >> 1) & 1) == 0);
      cyc();
      seen = seen | int'(running);
    end
    init = 1'b0;
    repeat (20) begin cyc(); seen = seen | int'(running); end
    chk("bounce_run", seen, 0);
    chk("bounce_cnt", cycle_count, 0);

    // 4. single step, twice
    n = 0;
    for (int p = 1; p <= 2; p++) begin
      step = 1'b1;
      repeat (10) begin cyc(); if (cpu_en) n++; end
      step = 1'b0;
      repeat (20) begin cyc(); if (cpu_en) n++; end
      chk("step_cnt", cycle_count, p);
      chk("step_idle", running | halted, 0);
    end
    chk("step_pulses", n, 2);

    // 5. halt while running, then resume with a fresh init rise
    do_reset();
    init = 1'b1;
    wait_running("halt_prerun", 20);
    repeat (6) cyc();
    g = 0;
    while (cpu_en !== 1'b1 && g < 10) begin cyc(); g++; end
    chk("halt_en_seen", cpu_en, 1);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    chk("halted", halted, 1);
    seen = 0;
    repeat (20) begin cyc(); seen = seen | int'(cpu_en); end
    chk("halt_noen", seen, 0);
    init = 1'b0;
    repeat (10) cyc();
    chk("halt_sticky", halted, 1);
    init = 1'b1;
    wait_running("rerun", 20);

    // 6. saturation, then reset during RUN
    g = 0;
    while (cycle_count != 8'd255 && g < 1000) begin cyc(); g++; end
    chk("sat255", cycle_count, 255);
    repeat (10) cyc();
    chk("sat_hold", cycle_count, 255);
    rst = 1'b0;
    cyc();
    chk("mid_rst_en", cpu_en, 0);
    chk("mid_rst_run", running, 0);
    chk("mid_rst_halt", halted, 0);
    chk("mid_rst_cnt", cycle_count, 0);
    rst = 1'b1;

    // randomized phase
    for (int s = 0; s < 300; s++) begin
      int hold;
      init = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        halt_req = ($urandom_range(0, 5) == 0);
        rst = ($urandom_range(0, 199) != 0);
        cyc();
      end
    end
    rst = 1'b1;
    halt_req = 1'b0;
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
